// File: rtl/alu_result_writer_if.sv
// ALU-to-result-RAM bundle for alu_result_writer: accumulator inputs, strobes,
// RAM write port and status outputs.
interface alu_result_writer_if #(
    parameter int RES_W  = 18,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 8
);
    logic [RES_W-1:0]  MU1;
    logic [RES_W-1:0]  MU2;
    logic [RES_W-1:0]  MU3;
    logic [RES_W-1:0]  MU4;
    logic              four_results_ready;
    logic              all_results_ready;
    logic [RAM_AW-1:0] base_addr;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              busy;
    logic              done;
    logic              overrun;
    logic [RES_W-1:0]  max_val;
    logic [RAM_AW-1:0] max_idx;

    modport master (
        output MU1, MU2, MU3, MU4, four_results_ready, all_results_ready, base_addr,
        input  ram_we, ram_addr, ram_wdata, busy, done, overrun, max_val, max_idx
    );

    modport slave (
        input  MU1, MU2, MU3, MU4, four_results_ready, all_results_ready, base_addr,
        output ram_we, ram_addr, ram_wdata, busy, done, overrun, max_val, max_idx
    );
endinterface

// File: rtl/alu_result_writer.sv
// Captures four ALU row results per group and serialises them into the result RAM.
// Optional running-maximum tracker enabled by macro RESULT_MAX_EN.
module alu_result_writer #(
    parameter int RES_W  = 18,
    parameter int DATA_W = 32,
    parameter int RAM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    alu_result_writer_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_ready_d1;
    logic              r_last_d1;
    logic              r_last_buf;
    logic              r_in_matrix;
    logic              r_overrun;
    logic [1:0]        r_k;
    logic [RAM_AW-1:0] r_ptr;
    logic [RES_W-1:0]  r_buf [4];
    logic              w_capture;
    logic              w_we;
    logic              w_busy;
    logic              w_done;

    assign w_capture = r_ready_d1;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_capture) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_we   = 1'b1;
                w_busy = 1'b1;
                if (r_k == 2'd3) w_state_nxt = r_last_buf ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pointer follows base_addr only between matrices; mid-matrix groups continue contiguously.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready_d1  <= 1'b0;
            r_last_d1   <= 1'b0;
            r_last_buf  <= 1'b0;
            r_in_matrix <= 1'b0;
            r_overrun   <= 1'b0;
            r_k         <= '0;
            r_ptr       <= '0;
            for (int unsigned i = 0; i < 4; i++) r_buf[i] <= '0;
        end else begin
            r_ready_d1 <= bus.four_results_ready;
            r_last_d1  <= bus.all_results_ready;
            if (w_capture && (r_state != S_IDLE)) r_overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (!r_in_matrix) r_ptr <= bus.base_addr;
                    if (w_capture) begin
                        r_buf[0]    <= bus.MU1;
                        r_buf[1]    <= bus.MU2;
                        r_buf[2]    <= bus.MU3;
                        r_buf[3]    <= bus.MU4;
                        r_last_buf  <= r_last_d1;
                        r_k         <= '0;
                        r_in_matrix <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    r_ptr <= r_ptr + 1'b1;
                    r_k   <= r_k + 1'b1;
                end
                S_DONE: begin
                    r_ptr       <= bus.base_addr;
                    r_in_matrix <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we    = w_we;
    assign bus.ram_addr  = w_we ? r_ptr : '0;
    assign bus.ram_wdata = w_we ? DATA_W'(r_buf[r_k]) : '0;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.overrun   = r_overrun;

`ifdef RESULT_MAX_EN
    logic [RAM_AW-1:0] r_base;
    logic [RES_W-1:0]  r_max_val;
    logic [RAM_AW-1:0] r_max_idx;

    // Strict greater-than keeps the earliest index on ties.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_base    <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
        end else begin
            if ((r_state == S_IDLE) && !r_in_matrix) r_base <= bus.base_addr;
            if (r_state == S_DONE) begin
                r_max_val <= '0;
                r_max_idx <= '0;
            end else if (w_we && (r_buf[r_k] > r_max_val)) begin
                r_max_val <= r_buf[r_k];
                r_max_idx <= r_ptr - r_base;
            end
        end
    end

    assign bus.max_val = r_max_val;
    assign bus.max_idx = r_max_idx;
`else
    assign bus.max_val = '0;
    assign bus.max_idx = '0;
`endif
endmodule

// File: tb/tb_alu_result_writer.sv
// Self-checking bench for alu_result_writer: vector table plus directed
// sequences for overrun, wrap, matrix contiguity and mid-drain reset.
module tb_alu_result_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    alu_result_writer_if #(.RES_W(18), .DATA_W(32), .RAM_AW(8)) u_if ();

    alu_result_writer #(.RES_W(18), .DATA_W(32), .RAM_AW(8)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(u_if.slave)
    );

    typedef struct {
        logic [7:0]       base;
        logic [3:0][17:0] mu;
        logic             last;
        logic [7:0]       addr0;
        logic             done;
        logic [17:0]      mx;
        logic [7:0]       mxi;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [17:0] a, input logic [17:0] b,
                                       input logic [17:0] c, input logic [17:0] d);
        return {d, c, b, a};
    endfunction

    task automatic drive_mu(input logic [3:0][17:0] mu);
        u_if.MU1 = mu[0];
        u_if.MU2 = mu[1];
        u_if.MU3 = mu[2];
        u_if.MU4 = mu[3];
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".we"},      32'(u_if.ram_we),    32'd0);
        chk({tag, ".addr"},    32'(u_if.ram_addr),  32'd0);
        chk({tag, ".wdata"},   u_if.ram_wdata,      32'd0);
        chk({tag, ".busy"},    32'(u_if.busy),      32'd0);
        chk({tag, ".done"},    32'(u_if.done),      32'd0);
        chk({tag, ".overrun"}, 32'(u_if.overrun),   32'd0);
        chk({tag, ".max_val"}, 32'(u_if.max_val),   32'd0);
        chk({tag, ".max_idx"}, 32'(u_if.max_idx),   32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        u_if.four_results_ready = 1'b0;
        u_if.all_results_ready  = 1'b0;
        u_if.base_addr = 8'h00;
        drive_mu(72'd0);
        @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [7:0] addr, input logic [17:0] data);
        chk({tag, ".we"},    32'(u_if.ram_we),   32'd1);
        chk({tag, ".addr"},  32'(u_if.ram_addr), 32'(addr));
        chk({tag, ".wdata"}, u_if.ram_wdata,     32'(data));
        chk({tag, ".busy"},  32'(u_if.busy),     32'd1);
    endtask

    // Strobe at E0, valid MU only between E0 and E1 so capture alignment is exercised.
    task automatic run_group(input string tag, input logic [7:0] base, input logic [3:0][17:0] mu,
                             input logic last, input logic [7:0] addr0, input logic exp_done,
                             input logic [17:0] mx, input logic [7:0] mxi);
        logic [17:0] emx;
        logic [7:0]  emi;
`ifdef RESULT_MAX_EN
        emx = mx;
        emi = mxi;
`else
        emx = '0;
        emi = '0;
`endif
        @(negedge clk);
        u_if.base_addr = base;
        u_if.four_results_ready = 1'b1;
        u_if.all_results_ready  = last;
        drive_mu({4{18'h2AAAA}});
        @(posedge clk);
        @(negedge clk);
        u_if.four_results_ready = 1'b0;
        u_if.all_results_ready  = 1'b0;
        drive_mu(mu);
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            if (j == 0) drive_mu({4{18'h15555}});
            check_write($sformatf("%s.w%0d", tag, j), addr0 + 8'(j), mu[j]);
            chk($sformatf("%s.w%0d.done", tag, j), 32'(u_if.done), 32'd0);
        end
        @(negedge clk);
        chk({tag, ".c5.we"},   32'(u_if.ram_we), 32'd0);
        chk({tag, ".c5.busy"}, 32'(u_if.busy),   32'd0);
        chk({tag, ".c5.done"}, 32'(u_if.done),   32'(exp_done));
        if (exp_done) begin
            chk({tag, ".max_val"}, 32'(u_if.max_val), 32'(emx));
            chk({tag, ".max_idx"}, 32'(u_if.max_idx), 32'(emi));
        end
        @(negedge clk);
        chk({tag, ".c6.done"}, 32'(u_if.done),   32'd0);
        chk({tag, ".c6.we"},   32'(u_if.ram_we), 32'd0);
        if (exp_done) chk({tag, ".max_clr"}, 32'(u_if.max_val), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        u_if.four_results_ready = 1'b0;
        u_if.all_results_ready  = 1'b0;
        u_if.base_addr = 8'h00;
        drive_mu(72'd0);

        vecs[0] = '{base: 8'h10, mu: mk(18'd5, 18'd6, 18'd7, 18'd8), last: 1'b0,
                    addr0: 8'h10, done: 1'b0, mx: 18'd0, mxi: 8'd0};
        vecs[1] = '{base: 8'h40, mu: mk(18'd1, 18'd2, 18'd3, 18'd4), last: 1'b1,
                    addr0: 8'h14, done: 1'b1, mx: 18'd8, mxi: 8'd3};
        vecs[2] = '{base: 8'hFE, mu: mk(18'hA, 18'hB, 18'hC, 18'hD), last: 1'b1,
                    addr0: 8'hFE, done: 1'b1, mx: 18'hD, mxi: 8'd3};
        vecs[3] = '{base: 8'h20, mu: mk(18'h3FFFF, 18'h0, 18'h12345, 18'h1), last: 1'b1,
                    addr0: 8'h20, done: 1'b1, mx: 18'h3FFFF, mxi: 8'd0};
        vecs[4] = '{base: 8'h30, mu: mk(18'd3, 18'h3FFFF, 18'h3FFFF, 18'd1), last: 1'b1,
                    addr0: 8'h30, done: 1'b1, mx: 18'h3FFFF, mxi: 8'd1};
        vecs[5] = '{base: 8'h00, mu: mk(18'd9, 18'd9, 18'd9, 18'd9), last: 1'b1,
                    addr0: 8'h00, done: 1'b1, mx: 18'd9, mxi: 8'd0};

        do_reset();
        for (int i = 0; i < 6; i++)
            run_group($sformatf("vec%0d", i), vecs[i].base, vecs[i].mu, vecs[i].last,
                      vecs[i].addr0, vecs[i].done, vecs[i].mx, vecs[i].mxi);

        // Full 16-word matrix, then the next matrix restarts at base_addr.
        do_reset();
        for (int g = 0; g < 4; g++) begin
            run_group($sformatf("mat.g%0d", g), 8'h10,
                      mk(18'(4*g+1), 18'(4*g+2), 18'(4*g+3), 18'(4*g+4)),
                      (g == 3), 8'(8'h10 + 4*g), (g == 3), 18'd16, 8'd15);
            @(negedge clk);
        end
        run_group("mat.next", 8'h10, mk(18'h100, 18'h300, 18'h200, 18'h050), 1'b1,
                  8'h10, 1'b1, 18'h300, 8'd1);

        // Overrun: second strobe lands mid-drain and is dropped.
        do_reset();
        @(negedge clk);
        u_if.base_addr = 8'h10;
        u_if.four_results_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        u_if.four_results_ready = 1'b0;
        drive_mu(mk(18'h11, 18'h22, 18'h33, 18'h44));
        @(posedge clk);
        @(negedge clk);
        check_write("ovr.w0", 8'h10, 18'h11);
        u_if.four_results_ready = 1'b1;
        u_if.all_results_ready  = 1'b1;
        drive_mu({4{18'h2AAAA}});
        @(negedge clk);
        check_write("ovr.w1", 8'h11, 18'h22);
        u_if.four_results_ready = 1'b0;
        u_if.all_results_ready  = 1'b0;
        drive_mu({4{18'h00099}});
        @(negedge clk);
        check_write("ovr.w2", 8'h12, 18'h33);
        chk("ovr.flag", 32'(u_if.overrun), 32'd1);
        @(negedge clk);
        check_write("ovr.w3", 8'h13, 18'h44);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("ovr.idle%0d.we", c), 32'(u_if.ram_we), 32'd0);
            chk($sformatf("ovr.idle%0d.done", c), 32'(u_if.done), 32'd0);
        end
        run_group("ovr.next", 8'h80, mk(18'd1, 18'd2, 18'd3, 18'd4), 1'b1,
                  8'h14, 1'b1, 18'h44, 8'd3);
        chk("ovr.sticky", 32'(u_if.overrun), 32'd1);

        // Lone all_results_ready must not start anything.
        do_reset();
        @(negedge clk);
        u_if.all_results_ready = 1'b1;
        @(negedge clk);
        u_if.all_results_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("lone%0d.we", c), 32'(u_if.ram_we), 32'd0);
            chk($sformatf("lone%0d.busy", c), 32'(u_if.busy), 32'd0);
        end
        run_group("lone.grp", 8'h70, mk(18'h7, 18'h6, 18'h5, 18'h4), 1'b0,
                  8'h70, 1'b0, 18'd0, 8'd0);

        // Reset after the 2nd write of a last group.
        do_reset();
        @(negedge clk);
        u_if.base_addr = 8'h50;
        u_if.four_results_ready = 1'b1;
        u_if.all_results_ready  = 1'b1;
        drive_mu(mk(18'd1, 18'd2, 18'd3, 18'd4));
        @(posedge clk);
        @(negedge clk);
        u_if.four_results_ready = 1'b0;
        u_if.all_results_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_write("mid.w0", 8'h50, 18'd1);
        @(negedge clk);
        check_write("mid.w1", 8'h51, 18'd2);
        rst = 1'b1;
        @(negedge clk);
        check_zero("mid.rst");
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("mid.after%0d.we", c), 32'(u_if.ram_we), 32'd0);
            chk($sformatf("mid.after%0d.done", c), 32'(u_if.done), 32'd0);
        end
        run_group("mid.restart", 8'h60, mk(18'd1, 18'd2, 18'd3, 18'd4), 1'b1,
                  8'h60, 1'b1, 18'd4, 8'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_result_writer.md
# alu_result_writer

- Downstream stage of the MAC ALU. Captures the four 18-bit row accumulators (MU1..MU4) each time a group of results completes, and serialises them into a single-port result RAM, one word per cycle.
- Flags the end of a full matrix, detects overruns, and optionally tracks the largest result.
- Sits between the ALU and the result RAM / readout controller.

## Interface

Parameters:
- RES_W, 18, width of each ALU result.
- DATA_W, 32, RAM word width; must be ≥ RES_W.
- RAM_AW, 8, RAM address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock, reset is synchronous and active-high.
- MU1..MU4  in  RES_W each  ALU accumulators, MU1 = lowest row.
- four_results_ready  in  1  ALU group-complete strobe.
- all_results_ready  in  1  ALU last-group strobe, coincident with four_results_ready.
- base_addr  in  RAM_AW  first RAM address of the matrix; sampled only in IDLE.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM write address.
- ram_wdata  out  DATA_W  zero-extended result.
- busy  out  1  high in DRAIN.
- done  out  1  one-cycle pulse after the last word of a matrix is written.
- overrun  out  1  sticky error flag.
- max_val  out  RES_W  largest result seen (RESULT_MAX_EN only).
- max_idx  out  RAM_AW  offset of max_val from base_addr (RESULT_MAX_EN only).

## Operation

**Reset values.** All outputs are 0. Internally: state = IDLE, write pointer = 0, ready_d1 = 0, last_d1 = 0.

**Input alignment.**
- ALU strobes are asserted one cycle before the matching MU values are registered.
- The block registers four_results_ready → ready_d1 and all_results_ready → last_d1.
- MU1..MU4 are captured at the edge where ready_d1 = 1.

**FSM states.**
- IDLE:
  - The write pointer loads base_addr.
  - On capture, latch MU1..MU4 into a 4-entry buffer, latch last_d1, go to DRAIN, set index k = 0.
- DRAIN:
  - Each cycle: ram_we = 1, ram_addr = pointer, ram_wdata = {zero, buf[k]}.
  - Then pointer+1 and k+1.
  - After the k = 3 write: go to IDLE, or to DONE if the latched last flag is set.
  - Pointer wraps modulo 2^RAM_AW with no error.
- DONE:
  - done = 1 for one cycle.
  - Pointer reloads base_addr.
  - Go to IDLE.

**Boundary conditions.**
- Pointer behaviour across groups:
  - The pointer is not reset between groups of one matrix; groups are written contiguously.
  - The pointer reloads base_addr only after done.
- Capture while in DRAIN or DONE:
  - The incoming group is dropped and overrun is set.
  - overrun clears only on rst.
  - The buffer is not corrupted.
- all_results_ready without four_results_ready is ignored.
- rst mid-DRAIN: ram_we drops on the next cycle. Partially written data stays in the RAM; no done pulse is issued.

## Timing

- Let E0 be the edge that samples four_results_ready = 1, and E1 the next edge (capture).
- ram_we is high for exactly 4 consecutive cycles, starting in the cycle after E1, writing MU1, MU2, MU3, MU4 in that order.
- busy follows the same 4-cycle window.
- done is high in the cycle after the 4th write (the 5th cycle after E1).
- Latency from strobe to first write is 2 cycles.
- The drain takes 4 cycles; the ALU's 8-cycle group period gives 4 spare cycles.
- Throughput: one group per 5 cycles minimum (6 cycles if the group is the last of a matrix).

## Configuration

- Macro: RESULT_MAX_EN.
- Defined:
  - On every write, if buf[k] > max_val (unsigned), update max_val and set max_idx = write offset from base_addr.
  - On a tie the earlier index is kept.
  - max_val/max_idx clear at rst and in DONE → IDLE after done; values are valid while done = 1.
- Undefined: max_val and max_idx are tied to 0 and the compare logic is absent.

## Test plan

- Single group: base_addr = 0x10, strobe with MU = 5, 6, 7, 8 → writes (0x10, 5), (0x11, 6), (0x12, 7), (0x13, 8) on consecutive cycles starting 2 cycles after the strobe; no done.
- Full matrix: 4 groups spaced 8 cycles, last with all_results_ready → 16 writes at 0x10–0x1F, done pulses once, 5 cycles after the last capture edge; next matrix starts again at 0x10.
- Overrun: second strobe 2 cycles after the first → only the first group is written, overrun = 1 and stays 1 until rst.
- Wrap: base_addr = 0xFE, one group → addresses 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-DRAIN: assert rst after the 2nd write → ram_we = 0 next cycle, no done, all outputs 0.
- RESULT_MAX_EN: values 3, 0x3FFFF, 0x3FFFF, 1 → max_val = 0x3FFFF, max_idx = 1 while done is high; without the macro both read 0.
